dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder: target end of the control unit's load/store path.
//   Accepts one request per handshake and services it after a programmable wait.
//   Handles byte, half and word lanes with RISC-V func3 encoding, then returns
//   extended load data or a write acknowledge.
//   Sits between the datapath/control unit and the word-organised data RAM.
// PARAMETERS
//   DEPTH_WORDS  256  RAM size in 32-bit words; valid byte addr < 4*DEPTH_WORDS
//   LATENCY      1    wait cycles between accept and response, 0..15
// PORTS
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   synchronous, active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept (high only in IDLE)
//   req_we     in   1   1 = store, 0 = load
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data; low byte/half used for sb/sh
//   req_func3  in   3   access size/sign (RISC-V func3)
//   rsp_valid  out  1   one-cycle response strobe
//   rsp_rdata  out  32  load result; 0 for stores and errors
//   rsp_err    out  1   request faulted; valid with rsp_valid
// BEHAVIOUR
//   Reset values: state=IDLE, req_ready=0 while rst high, rsp_valid=0,
//     rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents are not cleared.
//   FSM states:
//     IDLE: req_ready=1.
//       req_valid&req_ready latches we/addr/wdata/func3.
//       Next state is WAIT with cnt=LATENCY-1, or RESP if LATENCY=0.
//     WAIT: cnt decrements each cycle; at cnt=0, next state is RESP.
//     RESP: rsp_valid=1 for exactly one cycle, then IDLE.
//   Timing:
//     Access (RAM read or write) happens on the edge entering RESP, using latched fields.
//     Accept at edge t gives rsp_valid high in cycle t+1+LATENCY.
//     Throughput: one request per LATENCY+2 cycles.
//     req_valid while not IDLE is ignored; the requester holds it.
//   Loads:
//     000 lb  sign-extend byte[addr[1:0]]
//     001 lh  sign-extend half[addr[1]]
//     010 lw  full word
//     100 lbu zero-extend byte
//     101 lhu zero-extend half
//   Stores: 000 sb, 001 sh, 010 sw; only the addressed byte lanes are written.
//   Little-endian: byte 0 is word[7:0].
//   Errors (rsp_err=1, rsp_rdata=0, no RAM write):
//     - illegal func3 for the direction (store 1xx, load 011/11x)
//     - addr[31:2] >= DEPTH_WORDS
//     - misalignment when DMEM_MISALIGN_CHK_EN is defined
//   rsp_rdata/rsp_err hold their value until the next RESP.
//   Reset mid-operation: goes to IDLE; an uncommitted store is dropped;
//     no rsp_valid is produced.
//   Boundaries:
//     last word (addr 4*DEPTH_WORDS-4) is legal; addr 4*DEPTH_WORDS is an error.
//     LATENCY=0 skips WAIT entirely.
// CONFIGURATION
//   DMEM_MISALIGN_CHK_EN defined:
//     lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, sets rsp_err=1,
//     rsp_rdata=0 and suppresses the write.
//   DMEM_MISALIGN_CHK_EN undefined:
//     low address bits below the access size are ignored (forced alignment);
//     no misalignment error.
// TESTING
//   1) Reset: rst=1 for 2 cycles -> req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0;
//      req_ready=1 the cycle after rst falls.
//   2) LATENCY=1, sw 0xDEADBEEF @0x10 then lw @0x10
//      -> rsp_valid 2 cycles after each accept; lw returns 0xDEADBEEF, err=0.
//   3) sb 0x80 @0x13, then lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080;
//      lw @0x10 -> 0x80ADBEEF.
//   4) req_valid held high during WAIT/RESP -> not accepted until IDLE;
//      exactly one rsp_valid per accept.
//   5) sw @0x400 with DEPTH_WORDS=256 -> rsp_err=1, no write;
//      lw func3=011 -> rsp_err=1, rsp_rdata=0.
//   6) lw @0x12: with macro -> err=1, rdata=0; without macro -> word @0x10 returned.
//      Also assert rst during WAIT of an sw -> no response, target word unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Brief   : Data-memory responder for the load/store path. It accepts one
//           request per handshake and waits LATENCY cycles. It then performs
//           a byte, half or word access with RISC-V func3 encoding on a
//           word-organised RAM. Loads return extended data; stores return an
//           acknowledge.
// Config  : DMEM_MISALIGN_CHK_EN - when defined, misaligned half/word
//           accesses fault. When undefined, the low address bits are ignored.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,  // RAM words; needs to be at least 2
  parameter int LATENCY     = 1     // wait cycles between accept and response, 0..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_func3,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int         c_AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        w_accept, w_latch, w_enter_resp;

  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_func3;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  // Access-time view of the request. With zero latency the access happens on
  // the accept edge itself, so the live inputs are used instead of the latches.
  logic        w_acc_we;
  logic [31:0] w_acc_addr, w_acc_wdata;
  logic [2:0]  w_acc_func3;
  logic [29:0] w_word;
  logic [c_AW-1:0] w_idx;
  logic        w_oob, w_f3_bad, w_mis, w_err;
  logic [31:0] w_rd_word, w_load_data, w_rsp_data, w_wr_lanes;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_wmask;

  assign o_req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept    = i_req_valid && o_req_ready;
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

  assign w_acc_we    = (r_state == S_IDLE) ? i_req_we    : r_we;
  assign w_acc_addr  = (r_state == S_IDLE) ? i_req_addr  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? i_req_wdata : r_wdata;
  assign w_acc_func3 = (r_state == S_IDLE) ? i_req_func3 : r_func3;

  assign w_word    = w_acc_addr[31:2];
  assign w_idx     = w_word[c_AW-1:0];
  assign w_oob     = ({2'b00, w_word} >= 32'(DEPTH_WORDS));
  assign w_rd_word = r_mem[w_idx];

  // Illegal func3: stores allow only 000/001/010; loads also allow 100/101.
  assign w_f3_bad = w_acc_we ? (w_acc_func3[2] || (w_acc_func3[1:0] == 2'b11))
                             : ((w_acc_func3[1:0] == 2'b11) || (w_acc_func3[2:1] == 2'b11));

`ifdef DMEM_MISALIGN_CHK_EN
  assign w_mis = ((w_acc_func3[1:0] == 2'b01) && w_acc_addr[0]) ||
                 ((w_acc_func3[1:0] == 2'b10) && (w_acc_addr[1:0] != 2'b00));
`else
  assign w_mis = 1'b0;
`endif

  assign w_err = w_f3_bad || w_oob || w_mis;

  // Lane selection for loads and stores. Little-endian byte order is used.
  // The low address bits below the access size are ignored here.
  always_comb begin
    w_byte      = 8'h00;
    w_wmask     = 4'b0000;
    w_wr_lanes  = 32'h0;
    w_load_data = 32'h0;
    case (w_acc_addr[1:0])
      2'd0:    w_byte = w_rd_word[7:0];
      2'd1:    w_byte = w_rd_word[15:8];
      2'd2:    w_byte = w_rd_word[23:16];
      default: w_byte = w_rd_word[31:24];
    endcase
    w_half = w_acc_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    case (w_acc_func3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_data = w_rd_word;
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = 32'h0;
    endcase
    case (w_acc_func3[1:0])
      2'b00: begin
        w_wmask    = 4'b0001 << w_acc_addr[1:0];
        w_wr_lanes = {4{w_acc_wdata[7:0]}};
      end
      2'b01: begin
        w_wmask    = w_acc_addr[1] ? 4'b1100 : 4'b0011;
        w_wr_lanes = {2{w_acc_wdata[15:0]}};
      end
      default: begin
        w_wmask    = 4'b1111;
        w_wr_lanes = w_acc_wdata;
      end
    endcase
  end

  assign w_rsp_data = (w_err || w_acc_we) ? 32'h0 : w_load_data;

  // Next-state logic: IDLE accepts, WAIT counts down, RESP strobes once.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_latch = 1'b1;
          if (LATENCY == 0) begin
            w_state_next = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = c_WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register, request latches and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_func3 <= 3'b000;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_we    <= i_req_we;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_func3 <= i_req_func3;
      end
      if (w_enter_resp) begin
        r_rdata <= w_rsp_data;
        r_err   <= w_err;
      end
    end
  end

  // RAM write on the edge entering RESP. Reset blocks the write, so a
  // store that has not been committed is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_acc_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wr_lanes[8*i +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Self-checking bench for dmem_responder. It applies a table of
//           load/store vectors and a few hand-written multi-cycle sequences.
// Config  : DMEM_MISALIGN_CHK_EN selects the expected misalignment results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_func3 = 3'b000;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_we   (req_we),
    .i_req_addr (req_addr),
    .i_req_wdata(req_wdata),
    .i_req_func3(req_func3),
    .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3, input logic [31:0] rd, input logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
    v.exp_rdata = rd; v.exp_err = err;
    vecs.push_back(v);
  endtask

  // One complete request: handshake, bounded wait for the response, then
  // checks on latency, data, error and the single-cycle strobe.
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_err);
    int k;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_func3 = f3;
    req_valid = 1'b1;
    chk({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " latency"}, k, LAT);
    chk({tag, " rdata"}, rsp_rdata, exp_rd);
    chk({tag, " err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    @(posedge clk); #1;
    chk({tag, " strobe_1cyc"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rsp, ovl;

    // Reset behaviour
    @(posedge clk); @(posedge clk); #1;
    chk("rst ready", {31'h0, req_ready}, 32'h0);
    chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst rdata", rsp_rdata, 32'h0);
    chk("rst err", {31'h0, rsp_err}, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst ready", {31'h0, req_ready}, 32'h1);

    // Directed vector table
    add(1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        0); // sw
    add(0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0); // lw
    add(1, 32'h13,  32'h00000080, 3'b000, 32'h0,        0); // sb
    add(0, 32'h13,  32'h0,        3'b000, 32'hFFFFFF80, 0); // lb
    add(0, 32'h13,  32'h0,        3'b100, 32'h00000080, 0); // lbu
    add(0, 32'h10,  32'h0,        3'b010, 32'h80ADBEEF, 0); // lw
    add(1, 32'h14,  32'h11223344, 3'b010, 32'h0,        0); // sw
    add(1, 32'h16,  32'hFFFF8765, 3'b001, 32'h0,        0); // sh upper half
    add(0, 32'h14,  32'h0,        3'b010, 32'h87653344, 0); // lw
    add(0, 32'h16,  32'h0,        3'b001, 32'hFFFF8765, 0); // lh
    add(0, 32'h16,  32'h0,        3'b101, 32'h00008765, 0); // lhu
    add(0, 32'h14,  32'h0,        3'b001, 32'h00003344, 0); // lh low half
    add(0, 32'h15,  32'h0,        3'b000, 32'h00000033, 0); // lb byte1
    add(0, 32'h17,  32'h0,        3'b100, 32'h00000087, 0); // lbu byte3
    add(1, 32'h0,   32'h5555AAAA, 3'b010, 32'h0,        0); // sw word 0
    add(1, 32'h400, 32'hFFFFFFFF, 3'b010, 32'h0,        1); // sw out of range
    add(0, 32'h0,   32'h0,        3'b010, 32'h5555AAAA, 0); // word 0 untouched
    add(1, 32'h3FC, 32'hCAFEF00D, 3'b010, 32'h0,        0); // last word legal
    add(0, 32'h3FC, 32'h0,        3'b010, 32'hCAFEF00D, 0);
    add(0, 32'h400, 32'h0,        3'b010, 32'h0,        1); // lw out of range
    add(0, 32'h10,  32'h0,        3'b011, 32'h0,        1); // load func3 011
    add(0, 32'h10,  32'h0,        3'b110, 32'h0,        1); // load func3 110
    add(1, 32'h10,  32'h00000000, 3'b100, 32'h0,        1); // store func3 100
    add(0, 32'h10,  32'h0,        3'b010, 32'h80ADBEEF, 0); // no write happened
`ifdef DMEM_MISALIGN_CHK_EN
    add(0, 32'h12,  32'h0,        3'b010, 32'h0,        1); // misaligned lw
    add(0, 32'h17,  32'h0,        3'b001, 32'h0,        1); // misaligned lh
    add(1, 32'h11,  32'h01234567, 3'b010, 32'h0,        1); // misaligned sw
    add(0, 32'h10,  32'h0,        3'b010, 32'h80ADBEEF, 0); // suppressed
`else
    add(0, 32'h12,  32'h0,        3'b010, 32'h80ADBEEF, 0); // forced alignment
    add(0, 32'h17,  32'h0,        3'b001, 32'hFFFF8765, 0); // half[1] of 0x14
`endif

    foreach (vecs[i]) begin
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].f3, vecs[i].exp_rdata, vecs[i].exp_err);
    end

    // req_valid held high across WAIT/RESP: one response per accept
    acc = 0; rsp = 0; ovl = 0;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h10; req_func3 = 3'b010; req_valid = 1'b1;
    for (int i = 0; i < 3 * (LAT + 2); i++) begin
      if (req_valid && req_ready) acc++;
      if (rsp_valid) rsp++;
      if (rsp_valid && req_ready) ovl++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) rsp++;
      @(negedge clk);
    end
    chk("hold accepts", acc, 3);
    chk("hold responses", rsp, 3);
    chk("hold ready_in_resp", ovl, 0);
    chk("hold rdata_kept", rsp_rdata, 32'h80ADBEEF);

    // Reset asserted during WAIT of a store: no response, word unchanged
    do_req("pre-store", 1, 32'h20, 32'h0BADF00D, 3'b010, 32'h0, 0);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_func3 = 3'b010;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("midrst ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk); rst = 1'b0;
    rsp = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp++;
    end
    chk("midrst no_rsp", rsp, 0);
    do_req("midrst readback", 0, 32'h20, 32'h0, 3'b010, 32'h0BADF00D, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
